// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and the default
// oversample / payload widths used by the sender, receiver and baud generator.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  localparam int OVERSAMPLE_DEF = 8;
  localparam int DATA_BITS_DEF  = 8;

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side signal bundle: baud tick and serial line in, byte and
// status strobes out. The master modport drives the line, the slave receives.
interface uart_rx_if
  import uart_pkg::*;
#(
  parameter int DATA_BITS = DATA_BITS_DEF
);

  logic                 baud_tick;
  logic                 rx;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_done;
  logic                 rx_busy;
  logic                 frame_err;
  logic                 parity_err;

  modport master (
    output baud_tick, rx,
    input  rx_data, rx_done, rx_busy, frame_err, parity_err
  );

  modport slave (
    input  baud_tick, rx,
    output rx_data, rx_done, rx_busy, frame_err, parity_err
  );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input. The reset value is
// a parameter so an idle-high line does not look like a start edge.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Two back-to-back flops; the first may go metastable, the second settles it.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8N1 (LSB first), oversampled by the shared baud tick.
// Optional even-parity bit between data and stop when UART_RX_PARITY_EN
// is defined; otherwise parity_err is tied low.
//
// state  | meaning
// IDLE   | waiting; armed once line seen high, start on armed + low
// START  | counting to mid start bit to reject glitches
// DATA   | sampling payload bits at mid-bit, shifting in LSB first
// PARITY | sampling the even-parity bit (parity build only)
// STOP   | sampling the stop bit, issuing done / error strobe
module uart_rx
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int DATA_BITS  = DATA_BITS_DEF
) (
  input  logic     clk,
  input  logic     reset,
  uart_rx_if.slave bus
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);

  localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  logic rxs;

  rx_state_t            state_q,    state_d;
  logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
  logic [BW-1:0]        bit_cnt_q,  bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q,    shift_d;
  logic [DATA_BITS-1:0] data_q,     data_d;
  logic                 armed_q,    armed_d;
  logic                 done_q,     done_d;
  logic                 ferr_q,     ferr_d;
`ifdef UART_RX_PARITY_EN
  logic                 perr_q,     perr_d;
  logic                 pflag_q,    pflag_d;
`endif

  sync_2ff #(
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (bus.rx),
    .q_o   (rxs)
  );

  // State, counters, data and strobe registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      armed_q    <= 1'b0;
      done_q     <= 1'b0;
      ferr_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q     <= 1'b0;
      pflag_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      armed_q    <= armed_d;
      done_q     <= done_d;
      ferr_q     <= ferr_d;
`ifdef UART_RX_PARITY_EN
      perr_q     <= perr_d;
      pflag_q    <= pflag_d;
`endif
    end
  end

  // Next-state logic; everything holds except on baud ticks, strobes self-clear.
  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    data_d     = data_q;
    armed_d    = armed_q;
    done_d     = 1'b0;
    ferr_d     = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_d     = 1'b0;
    pflag_d    = pflag_q;
`endif

    if (bus.baud_tick) begin
      case (state_q)
        IDLE: begin
          if (armed_q && !rxs) begin
            state_d    = START;
            tick_cnt_d = '0;
            armed_d    = 1'b0;
          end else if (rxs) begin
            armed_d = 1'b1;
          end
        end

        START: begin
          if (tick_cnt_q == TICK_MID) begin
            tick_cnt_d = '0;
            if (!rxs) begin
              state_d   = DATA;
              bit_cnt_d = '0;
`ifdef UART_RX_PARITY_EN
              pflag_d   = 1'b0;
`endif
            end else begin
              state_d = IDLE;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end

        DATA: begin
          if (tick_cnt_q == TICK_LAST) begin
            shift_d    = {rxs, shift_q[DATA_BITS-1:1]};
            tick_cnt_d = '0;
            bit_cnt_d  = bit_cnt_q + 1'b1;
            if (bit_cnt_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end

`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (tick_cnt_q == TICK_LAST) begin
            pflag_d    = rxs ^ (^shift_q);
            tick_cnt_d = '0;
            state_d    = STOP;
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
`endif

        STOP: begin
          if (tick_cnt_q == TICK_LAST) begin
            tick_cnt_d = '0;
            state_d    = IDLE;
            if (!rxs) begin
              ferr_d = 1'b1;
`ifdef UART_RX_PARITY_EN
            end else if (pflag_q) begin
              perr_d = 1'b1;
`endif
            end else begin
              done_d = 1'b1;
              data_d = shift_q;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end

        default: begin
          state_d    = IDLE;
          tick_cnt_d = '0;
        end
      endcase
    end
  end

  assign bus.rx_data   = data_q;
  assign bus.rx_done   = done_q;
  assign bus.frame_err = ferr_q;
  assign bus.rx_busy   = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
  assign bus.parity_err = perr_q;
`else
  assign bus.parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: stimulus pushes expected strobes into a queue,
// a negedge monitor pops and compares whenever the receiver strobes.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int BIT_CLK = 32;
`ifdef UART_RX_PARITY_EN
  localparam int FRAME_CLK = 11 * BIT_CLK;
  localparam int N_DONE    = 7;
`else
  localparam int FRAME_CLK = 10 * BIT_CLK;
  localparam int N_DONE    = 6;
`endif

  typedef enum logic [1:0] {EV_DONE, EV_FERR, EV_PERR} ev_kind_t;
  typedef struct packed {
    ev_kind_t   kind;
    logic [7:0] data;
  } ev_t;

  logic clk = 1'b0;
  logic reset = 1'b1;

  uart_rx_if #(.DATA_BITS(8)) bus ();

  uart_rx #(
    .OVERSAMPLE (8),
    .DATA_BITS  (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  ev_t exp_q[$];
  int  done_cyc[$];
  int  n_checks = 0;
  int  n_fail   = 0;
  int  cyc      = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_ev(input ev_kind_t kind, input logic [7:0] data);
    ev_t e;
    e.kind = kind;
    e.data = data;
    exp_q.push_back(e);
  endtask

  // Baud tick: one clk high every 4 clk, so one bit is 8 ticks = 32 clk.
  initial begin
    bus.baud_tick = 1'b0;
    forever begin
      repeat (3) @(posedge clk);
      #1 bus.baud_tick = 1'b1;
      @(posedge clk);
      #1 bus.baud_tick = 1'b0;
    end
  end

  // Monitor: every strobe must match the oldest expected event.
  always @(negedge clk) begin
    ev_t      e;
    ev_kind_t got;
    if (!reset && (bus.rx_done || bus.frame_err || bus.parity_err)) begin
      check("strobe_onehot",
            32'(int'(bus.rx_done) + int'(bus.frame_err) + int'(bus.parity_err)), 1);
      got = bus.rx_done ? EV_DONE : (bus.frame_err ? EV_FERR : EV_PERR);
      if (bus.rx_done) done_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_strobe: got kind %0d, expected no strobe", got);
      end else begin
        e = exp_q.pop_front();
        check("strobe_kind", 32'(got), 32'(e.kind));
        check("rx_data", 32'(bus.rx_data), 32'(e.data));
        check("busy_at_strobe", 32'(bus.rx_busy), 0);
      end
    end
  end

  task automatic send_bit(input logic b);
    bus.rx = b;
    repeat (BIT_CLK) @(posedge clk);
    #1;
  endtask

  task automatic send_frame_raw(input logic [7:0] d, input logic has_par,
                                input logic par, input logic stop_b);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    if (has_par) send_bit(par);
    send_bit(stop_b);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b);
`ifdef UART_RX_PARITY_EN
    send_frame_raw(d, 1'b1, ^d, stop_b);
`else
    send_frame_raw(d, 1'b0, 1'b0, stop_b);
`endif
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int gap;
    bus.rx = 1'b1;
    reset  = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_rx_data", 32'(bus.rx_data), 0);
    check("rst_busy", 32'(bus.rx_busy), 0);
    check("rst_done", 32'(bus.rx_done), 0);
    check("rst_ferr", 32'(bus.frame_err), 0);
    check("rst_perr", 32'(bus.parity_err), 0);
    @(posedge clk);
    #1;
    send_bit(1'b1);
    send_bit(1'b1);

    // Single clean frame
    expect_ev(EV_DONE, 8'h55);
    send_frame(8'h55, 1'b1);
    send_bit(1'b1);
    check("busy_after_55", 32'(bus.rx_busy), 0);
    check("sb_drain_55", 32'(exp_q.size()), 0);

    // Back-to-back frames with a single stop bit
    expect_ev(EV_DONE, 8'hA3);
    expect_ev(EV_DONE, 8'h0F);
    send_frame(8'hA3, 1'b1);
    send_frame(8'h0F, 1'b1);
    send_bit(1'b1);
    n_checks++;
    if (done_cyc.size() < 3) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d done pulses, expected 3", done_cyc.size());
    end else begin
      gap = done_cyc[2] - done_cyc[1];
      if (gap < FRAME_CLK - 4 || gap > FRAME_CLK + 4) begin
        n_fail++;
        $display("FAIL b2b_gap: got %0d clk, expected %0d", gap, FRAME_CLK);
      end
    end

    // One-tick glitch must not qualify as a start bit
    bus.rx = 1'b0;
    repeat (4) @(posedge clk);
    #1 bus.rx = 1'b1;
    repeat (32) @(posedge clk);
    #1;
    check("busy_after_glitch", 32'(bus.rx_busy), 0);
    send_bit(1'b1);

    // Framing error then line stuck low
    expect_ev(EV_DONE, 8'h55);
    send_frame(8'h55, 1'b1);
    send_bit(1'b1);
    expect_ev(EV_FERR, 8'h55);
    send_frame(8'h3C, 1'b0);
    for (int i = 0; i < 20; i++) begin
      send_bit(1'b0);
      if (i % 4 == 3) check("busy_line_low", 32'(bus.rx_busy), 0);
    end
    check("data_after_ferr", 32'(bus.rx_data), 'h55);
    send_bit(1'b1);
    send_bit(1'b1);
    expect_ev(EV_DONE, 8'h81);
    send_frame(8'h81, 1'b1);
    send_bit(1'b1);

    // Reset in the middle of data bit 4 of 0xF0
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b0);
    bus.rx = 1'b1;
    repeat (16) @(posedge clk);
    #1;
    check("busy_mid_frame", 32'(bus.rx_busy), 1);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("mid_rst_rx_data", 32'(bus.rx_data), 0);
    check("mid_rst_busy", 32'(bus.rx_busy), 0);
    check("mid_rst_done", 32'(bus.rx_done), 0);
    check("mid_rst_ferr", 32'(bus.frame_err), 0);
    @(posedge clk);
    #1;
    repeat (14) @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    check("busy_after_abort", 32'(bus.rx_busy), 0);
    expect_ev(EV_DONE, 8'h81);
    send_frame(8'h81, 1'b1);
    send_bit(1'b1);

`ifdef UART_RX_PARITY_EN
    // 0x07 has three ones: even parity bit must be 1
    expect_ev(EV_PERR, 8'h81);
    send_frame_raw(8'h07, 1'b1, 1'b0, 1'b1);
    send_bit(1'b1);
    check("data_after_perr", 32'(bus.rx_data), 'h81);
    expect_ev(EV_DONE, 8'h07);
    send_frame_raw(8'h07, 1'b1, 1'b1, 1'b1);
    send_bit(1'b1);
`endif

    repeat (20) @(posedge clk);
    #1;
    check("sb_empty", 32'(exp_q.size()), 0);
    check("done_count", 32'(done_cyc.size()), 32'(N_DONE));
    check("final_busy", 32'(bus.rx_busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Asynchronous serial receiver; counterpart to the UART sender path.
- Consumes the shared 8x-oversample baud tick (one-clk pulse at BAUD*OVERSAMPLE).
- Deserialises 8N1 frames, LSB first, from the rx pin.
- Presents each byte to the downstream command/control logic with a one-cycle done strobe.

Parameters:
- OVERSAMPLE, 8: ticks per bit period; must be even and >= 4.
- DATA_BITS, 8: payload bits per frame.

Ports:
- clk  input  1  system clock (100 MHz).
- reset  input  1  synchronous, active-high reset.
- baud_tick  input  1  oversample tick, one clk wide, from the baud tick generator.
- rx  input  1  asynchronous serial line; idle high.
- rx_data  output  DATA_BITS  last correctly received byte.
- rx_done  output  1  one-clk strobe; rx_data newly valid.
- rx_busy  output  1  high from start-bit qualification until frame end.
- frame_err  output  1  one-clk strobe; stop bit sampled low.
- parity_err  output  1  one-clk strobe; parity mismatch (see Optional Feature).

Behaviour:
- Reset values:
  - rx_data=0; rx_done, rx_busy, frame_err, parity_err=0.
  - Synchroniser flops=1; state=IDLE; armed=0; all counters 0.
- Synchronisation:
  - rx passes through a 2-flop synchroniser (rxs) before any use.
  - Adds 2 clk of latency.
- Sampling: all state and counter updates occur only on cycles where baud_tick=1. Cycles without a tick hold all state.
- IDLE:
  - On a tick with rxs=1, set armed=1.
  - On a tick with armed=1 and rxs=0: go to START, tick_cnt=0.
  - armed is cleared on leaving IDLE, so a line held low never starts a frame.
- START:
  - Each tick increments tick_cnt.
  - On the tick where tick_cnt=OVERSAMPLE/2-1 (mid start bit):
    - rxs=0: go to DATA, tick_cnt=0, bit_cnt=0.
    - rxs=1: false start; return to IDLE with no strobe.
- DATA:
  - On the tick where tick_cnt=OVERSAMPLE-1: shift rxs into shift_reg MSB side (LSB-first frame), tick_cnt=0, bit_cnt++.
  - After bit DATA_BITS-1: go to STOP, or to PARITY when the macro is enabled.
  - Otherwise tick_cnt++.
- STOP:
  - On the tick where tick_cnt=OVERSAMPLE-1, sample rxs and return to IDLE.
  - Sample 1: rx_data<=shift_reg and rx_done=1 for the next clk.
  - Sample 0: frame_err=1 for the next clk; rx_data unchanged; rx_done=0.
- rx_busy is 1 in START, DATA, STOP and PARITY; it drops in the same clk the strobe rises.
- Back-to-back frames: the stop sample lands mid stop bit, so IDLE re-arms on the remaining stop-bit ticks. The next start edge is caught with no lost frame.
- Reset mid-frame: the partial frame is discarded with no strobe. The next frame needs the line to be seen high first (armed rule).
- Strobes are registered; at most one of rx_done/frame_err/parity_err is high in any clk.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - A PARITY state follows DATA and samples one even-parity bit at tick_cnt=OVERSAMPLE-1.
  - A mismatch sets a flag. At STOP, a flagged frame gives parity_err=1 and no rx_done; rx_data is unchanged.
  - If the stop bit is also low, frame_err takes priority.
- Undefined: no PARITY state; parity_err tied 0; frame is 8N1.

Decomposition:
- Package uart_pkg holds:
  - rx_state_t enum {IDLE, START, DATA, PARITY, STOP}.
  - Localparams OVERSAMPLE_DEF=8 and DATA_BITS_DEF=8, shared with the sender and the baud generator.
- One sub-module: sync_2ff (2-flop synchroniser, reset value parameterised, here 1).

Test Plan:
- Setup: baud_tick every 4 clk, so 1 bit = 32 clk.
- Send 0x55, stop=1 -> exactly one rx_done pulse, rx_data=0x55, frame_err=0, rx_busy low afterwards.
- Send 0xA3 then 0x0F back to back with one stop bit -> two rx_done pulses ~320 clk apart; rx_data 0xA3 then 0x0F.
- Drive rx low for 1 tick period (4 clk) then high -> no START qualification, rx_busy=0 within 3 ticks, no strobes.
- After 0x55, send 0x3C with stop=0, then hold rx low for 20 bit times -> one frame_err pulse, rx_data stays 0x55, no further activity until rx returns high; a following 0x81 -> rx_done, rx_data=0x81.
- Assert reset for 1 clk during data bit 4 of 0xF0 -> all outputs 0 next clk, no strobe for the aborted frame; next 0x81 received correctly.
- With UART_RX_PARITY_EN:
  - Send 0x07 with parity bit 0 -> parity_err pulse, no rx_done.
  - Send 0x07 with parity bit 1 -> rx_done, rx_data=0x07.
